toggle_meter: RTL and testbench
===============================

TOGGLE_METER -- requirements
Module: toggle_meter

Interface
REQ-001 Parameter N_CH, default 4, number of monitored gate outputs (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-channel toggle counter.
REQ-003 Parameter E_TOG, default 25, energy units per toggle (C_L*Vcc^2 scaled to an integer, 1..255).
REQ-004 Port clk input 1: single clock, all state on its rising edge.
REQ-005 Port reset input 1: asynchronous, active-high reset.
REQ-006 Port sig_in input N_CH: gate outputs under measurement, synchronous to clk.
REQ-007 Port enable input 1: counting enabled when high.
REQ-008 Port clear input 1: synchronous clear of all counters and the sample register.
REQ-009 Port rd_req input 1: read request, one-cycle strobe.
REQ-010 Port rd_ch input 3: channel index, sampled with rd_req.
REQ-011 Port rd_ack input 1: consumer acknowledge of rd_data.
REQ-012 Port rd_busy output 1: high while a read is in progress (CALC or RESP).
REQ-013 Port rd_valid output 1: rd_data/rd_cnt valid.
REQ-014 Port rd_cnt output CNT_W: snapshot toggle count of the requested channel.
REQ-015 Port rd_energy output CNT_W+8: rd_cnt * E_TOG.
REQ-016 Port sat output N_CH: per-channel saturation flag.

Function
REQ-017 Each cycle, sig_in SHALL be registered into prev; channel i toggles when sig_in[i] != prev[i].
REQ-018 With enable high, each toggling channel counter SHALL increment by 1 in that same edge.
REQ-019 Counters SHALL saturate at 2^CNT_W-1, with sat[i] set on reaching it; no wrap-around.
REQ-020 With enable low, prev SHALL still update; no counting occurs; no toggle is counted on re-enable for past changes.
REQ-021 clear high SHALL zero all counters and sat, and load prev with sig_in; a toggle in the same cycle SHALL be dropped (clear wins).
REQ-022 Read FSM states: IDLE, CALC, RESP.
REQ-023 IDLE: rd_req high and rd_ch < N_CH -> latch counter[rd_ch] into a snapshot, go to CALC; rd_ch >= N_CH -> snapshot 0, go to CALC.
REQ-024 CALC: compute snapshot*E_TOG into rd_energy, go to RESP (one cycle).
REQ-025 RESP: rd_valid high, rd_cnt/rd_energy stable until rd_ack; rd_ack high -> IDLE in the next cycle.
REQ-026 Read latency: rd_valid SHALL assert 2 cycles after the rd_req edge.
REQ-027 rd_req outside IDLE SHALL be ignored; a rd_ack while not in RESP SHALL be ignored.
REQ-028 The snapshot taken in the rd_req cycle SHALL include neither that cycle's toggle nor a clear issued in that cycle.
REQ-029 Counting and clear SHALL continue during CALC/RESP without changing the presented values.
REQ-030 rd_energy SHALL be full-width and never overflow: CNT_W+8 bits covers E_TOG <= 255.

Reset
REQ-031 reset high SHALL immediately force counters=0, sat=0, prev=0, FSM=IDLE, rd_busy=0, rd_valid=0, rd_cnt=0, rd_energy=0.
REQ-032 Reset during CALC or RESP SHALL abort the read with no rd_valid pulse.
REQ-033 First edge after reset deassertion: prev is 0, so a high sig_in bit counts as one toggle if enable is high.

Structure
REQ-034 Package toggle_meter_pkg SHALL hold the FSM state encoding, default N_CH, CNT_W and E_TOG.
REQ-035 Sub-module toggle_det (one per channel) SHALL hold prev, the saturating counter and sat; the FSM and multiplier live in the top.

Verification
REQ-036 Reset, enable=1, toggle sig_in[0] 5 times, rd_req rd_ch=0 -> rd_valid 2 cycles later, rd_cnt=5, rd_energy=125.
REQ-037 CNT_W=4: 20 toggles on ch1 -> rd_cnt=15, sat[1]=1, no wrap.
REQ-038 Toggle ch2 in the same cycle as clear -> read ch2 returns 0.
REQ-039 rd_req during RESP, ack held off 3 cycles -> values stable, second request ignored, FSM back in IDLE the cycle after rd_ack.
REQ-040 Assert reset in CALC -> rd_valid never asserts, all outputs 0 immediately.
REQ-041 rd_ch=7 with N_CH=4 -> rd_cnt=0, rd_energy=0, normal handshake.

Source files
------------

// File: rtl/toggle_meter_pkg.sv
// Shared defaults and read-FSM state encoding for the toggle meter.
package toggle_meter_pkg;
    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_E_TOG = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } rd_state_e;
endpackage

// File: rtl/toggle_meter_det.sv
// Per-channel toggle detector: previous-value register, saturating counter, sat flag.
module toggle_det #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_i,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             sat_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             prev_q;
    logic             sat_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable_i && (sig_i != prev_q) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Clear wins over a toggle in the same cycle; prev tracks sig_i even when disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else if (clear_i) begin
            prev_q <= sig_i;
            cnt_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            prev_q <= sig_i;
            cnt_q  <= cnt_d;
            sat_q  <= (cnt_d == CNT_MAX);
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = sat_q;
endmodule

// File: rtl/toggle_meter.sv
// Multi-channel switching-activity meter with a snapshot/multiply/handshake read port.
module toggle_meter
    import toggle_meter_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int E_TOG = DEF_E_TOG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   sig_in,
    input  logic              enable,
    input  logic              clear,
    input  logic              rd_req,
    input  logic [2:0]        rd_ch,
    input  logic              rd_ack,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W+7:0]  rd_energy,
    output logic [N_CH-1:0]   sat
);
    localparam logic [CNT_W+7:0] E_MUL = (CNT_W+8)'(E_TOG);

    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]           sel_cnt;
    logic [CNT_W-1:0]           snap_q;
    logic [CNT_W-1:0]           rd_cnt_q;
    logic [CNT_W+7:0]           rd_energy_q;
    logic                       rd_busy_q, rd_valid_q;
    rd_state_e                  state_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_det
        toggle_det #(.CNT_W(CNT_W)) u_det (
            .clk      (clk),
            .reset    (reset),
            .sig_i    (sig_in[g]),
            .enable_i (enable),
            .clear_i  (clear),
            .cnt_o    (cnt[g]),
            .sat_o    (sat[g])
        );
    end

    // Out-of-range channel indices fall through to a zero snapshot.
    always_comb begin
        sel_cnt = '0;
        for (int i = 0; i < N_CH; i++)
            if (rd_ch == 3'(i)) sel_cnt = cnt[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            rd_cnt_q    <= '0;
            rd_energy_q <= '0;
            rd_busy_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (rd_req) begin
                    snap_q    <= sel_cnt;
                    rd_busy_q <= 1'b1;
                    state_q   <= ST_CALC;
                end
                ST_CALC: begin
                    rd_cnt_q    <= snap_q;
                    rd_energy_q <= (CNT_W+8)'(snap_q) * E_MUL;
                    rd_valid_q  <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: if (rd_ack) begin
                    rd_valid_q <= 1'b0;
                    rd_busy_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_busy   = rd_busy_q;
    assign rd_valid  = rd_valid_q;
    assign rd_cnt    = rd_cnt_q;
    assign rd_energy = rd_energy_q;
endmodule

// File: tb/tb_toggle_meter.sv
// Directed bench: default instance (CNT_W=16) and a narrow instance (CNT_W=4) share all inputs.
module tb_toggle_meter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  sig_in = '0;
    logic        enable = 1'b0, clear = 1'b0, rd_req = 1'b0, rd_ack = 1'b0;
    logic [2:0]  rd_ch = '0;

    logic        a_busy, a_valid, b_busy, b_valid;
    logic [15:0] a_cnt;
    logic [23:0] a_en;
    logic [3:0]  b_cnt;
    logic [11:0] b_en;
    logic [3:0]  a_sat, b_sat;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    toggle_meter u_a (
        .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable), .clear(clear),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_busy(a_busy),
        .rd_valid(a_valid), .rd_cnt(a_cnt), .rd_energy(a_en), .sat(a_sat));

    toggle_meter #(.N_CH(4), .CNT_W(4), .E_TOG(25)) u_b (
        .clk(clk), .reset(reset), .sig_in(sig_in), .enable(enable), .clear(clear),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack), .rd_busy(b_busy),
        .rd_valid(b_valid), .rd_cnt(b_cnt), .rd_energy(b_en), .sat(b_sat));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [2:0] ch);
        rd_ch = ch; rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
    endtask

    task automatic ack();
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({a_busy, a_valid, b_busy, b_valid} !== 4'b0) begin bad++; $display("FAIL reset_hs got=%b want=0000", {a_busy, a_valid, b_busy, b_valid}); end
        total++; if (a_cnt !== 16'd0 || a_en !== 24'd0) begin bad++; $display("FAIL reset_data got=%0d/%0d want=0/0", a_cnt, a_en); end
        total++; if (a_sat !== 4'd0 || b_sat !== 4'd0) begin bad++; $display("FAIL reset_sat got=%b/%b want=0000", a_sat, b_sat); end
    endtask

    task automatic test_basic();
        enable = 1'b1; reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin sig_in[0] = ~sig_in[0]; tick(); end
        issue_req(3'd0);
        total++; if (a_busy !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL basic_calc got busy=%b valid=%b want 1/0", a_busy, a_valid); end
        tick();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", a_valid); end
        total++; if (a_cnt !== 16'd5 || a_en !== 24'd125) begin bad++; $display("FAIL basic_a got=%0d/%0d want=5/125", a_cnt, a_en); end
        total++; if (b_cnt !== 4'd5 || b_en !== 12'd125) begin bad++; $display("FAIL basic_b got=%0d/%0d want=5/125", b_cnt, b_en); end
        ack();
        total++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL basic_ack got busy=%b valid=%b want 0/0", a_busy, a_valid); end
    endtask

    task automatic test_sat();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 20; i++) begin sig_in[1] = ~sig_in[1]; tick(); end
        total++; if (b_sat !== 4'b0010 || a_sat !== 4'b0000) begin bad++; $display("FAIL sat_flags got=%b/%b want=0010/0000", b_sat, a_sat); end
        issue_req(3'd1); tick();
        total++; if (b_cnt !== 4'd15 || b_en !== 12'd375) begin bad++; $display("FAIL sat_b got=%0d/%0d want=15/375", b_cnt, b_en); end
        total++; if (a_cnt !== 16'd20 || a_en !== 24'd500) begin bad++; $display("FAIL sat_a got=%0d/%0d want=20/500", a_cnt, a_en); end
        ack();
    endtask

    task automatic test_clear_toggle();
        sig_in[2] = ~sig_in[2]; clear = 1'b1;
        tick();
        clear = 1'b0;
        total++; if (b_sat !== 4'd0) begin bad++; $display("FAIL clr_sat got=%b want=0000", b_sat); end
        issue_req(3'd2); tick();
        total++; if (a_valid !== 1'b1 || a_cnt !== 16'd0 || a_en !== 24'd0) begin bad++; $display("FAIL clr_read got v=%b %0d/%0d want 1 0/0", a_valid, a_cnt, a_en); end
        ack();
    endtask

    task automatic test_snapshot_b2b();
        for (int i = 0; i < 3; i++) begin sig_in[3] = ~sig_in[3]; tick(); end
        // Same-cycle toggle and clear must not reach the snapshot.
        sig_in[3] = ~sig_in[3]; clear = 1'b1;
        issue_req(3'd3);
        clear = 1'b0;
        tick();
        total++; if (a_cnt !== 16'd3 || a_en !== 24'd75) begin bad++; $display("FAIL snap got=%0d/%0d want=3/75", a_cnt, a_en); end
        for (int i = 0; i < 3; i++) begin
            if (i < 2) sig_in[3] = ~sig_in[3];
            if (i == 0) begin rd_ch = 3'd0; rd_req = 1'b1; end
            tick();
            rd_req = 1'b0;
            total++; if (a_valid !== 1'b1 || a_cnt !== 16'd3 || a_en !== 24'd75) begin bad++; $display("FAIL hold%0d got v=%b %0d/%0d want 1 3/75", i, a_valid, a_cnt, a_en); end
        end
        ack();
        total++; if (a_valid !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b valid=%b want 0/0", a_busy, a_valid); end
        tick();
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL b2b_ignored got busy=%b want=0", a_busy); end
        issue_req(3'd3); tick();
        total++; if (a_cnt !== 16'd2 || a_en !== 24'd50) begin bad++; $display("FAIL count_during_read got=%0d/%0d want=2/50", a_cnt, a_en); end
        ack();
    endtask

    task automatic test_oob();
        issue_req(3'd7);
        total++; if (a_busy !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL oob_calc got busy=%b valid=%b want 1/0", a_busy, a_valid); end
        tick();
        total++; if (a_valid !== 1'b1 || a_cnt !== 16'd0 || a_en !== 24'd0) begin bad++; $display("FAIL oob_read got v=%b %0d/%0d want 1 0/0", a_valid, a_cnt, a_en); end
        ack();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL oob_ack got=%b want=0", a_valid); end
    endtask

    task automatic test_enable();
        clear = 1'b1; tick(); clear = 1'b0;
        enable = 1'b0; sig_in[0] = ~sig_in[0];
        tick();
        enable = 1'b1;
        tick();
        issue_req(3'd0); tick();
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL en_off got=%0d want=0", a_cnt); end
        ack();
        sig_in[0] = ~sig_in[0];
        tick();
        issue_req(3'd0); tick();
        total++; if (a_cnt !== 16'd1 || a_en !== 24'd25) begin bad++; $display("FAIL en_on got=%0d/%0d want=1/25", a_cnt, a_en); end
        ack();
    endtask

    task automatic test_reset_calc();
        issue_req(3'd0);
        reset = 1'b1;
        #1;
        total++; if ({a_busy, a_valid} !== 2'b00 || a_cnt !== 16'd0 || a_en !== 24'd0) begin bad++; $display("FAIL rst_calc got b=%b v=%b %0d/%0d want 0 0 0/0", a_busy, a_valid, a_cnt, a_en); end
        tick(); tick();
        total++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin bad++; $display("FAIL rst_novalid got=%b/%b want=0/0", a_valid, b_valid); end
        sig_in = 4'b0101; enable = 1'b1;
        reset = 1'b0;
        tick();
        issue_req(3'd2); tick();
        total++; if (a_cnt !== 16'd1 || a_en !== 24'd25) begin bad++; $display("FAIL first_edge got=%0d/%0d want=1/25", a_cnt, a_en); end
        ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_clear_toggle();
        test_snapshot_b2b();
        test_oob();
        test_enable();
        test_reset_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
